// File: rtl/cla_pkg.sv
// Shared defaults, mode encodings and pipeline sizing for the pipelined CLA adder.
package cla_pkg;

    localparam int unsigned DEF_BLK           = 4;
    localparam int unsigned DEF_BLK_PER_STAGE = 1;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int unsigned calc_nstage(int unsigned width, int unsigned blk,
                                                int unsigned bps);
        return width / (blk * bps);
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLK-bit carry-lookahead block with group propagate/generate outputs.
module cla_block #(
    parameter int unsigned BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout,
    output logic           p,
    output logic           g
);

    logic [BLK-1:0] gen;
    logic [BLK-1:0] prop;
    logic [BLK-1:0] c;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each bit carry is a flat sum of products over the lower bits, not a ripple chain.
    always_comb begin : carry_la
        logic acc;
        logic run;
        acc = 1'b0;
        run = 1'b1;
        c   = '0;
        for (int i = 0; i < BLK; i++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (run & gen[j]);
                run = run & prop[j];
            end
            c[i] = acc | (run & cin);
        end
    end

    // Kept apart from carry_la so the group terms never depend on cin.
    always_comb begin : group_la
        logic run;
        g   = 1'b0;
        run = 1'b1;
        for (int j = BLK - 1; j >= 0; j--) begin
            g   = g | (run & gen[j]);
            run = run & prop[j];
        end
    end

    assign p    = &prop;
    assign cout = g | (p & cin);
    assign s    = prop ^ c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: an input rank then one register rank per
// slice of BLK*BLK_PER_STAGE bits, all ranks stalling together under output backpressure.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned BLK           = DEF_BLK,
    parameter int unsigned BLK_PER_STAGE = DEF_BLK_PER_STAGE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned S      = BLK * BLK_PER_STAGE;
    localparam int unsigned NSTAGE = calc_nstage(WIDTH, BLK, BLK_PER_STAGE);

    if (S == 0 || NSTAGE == 0 || (WIDTH % S) != 0) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of BLK*BLK_PER_STAGE");
    end

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Input rank: operands already conditioned for add/sub.
    logic             in_v_q;
    logic             in_c_q;
    logic [WIDTH-1:0] in_a_q;
    logic [WIDTH-1:0] in_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_v_q <= 1'b0;
            in_c_q <= 1'b0;
            in_a_q <= '0;
            in_b_q <= '0;
        end else if (!stall) begin
            in_v_q <= in_valid;
            if (in_valid) begin
                in_a_q <= a;
                in_b_q <= (sub == MODE_SUB) ? ~b : b;
                in_c_q <= (sub == MODE_ADD) ? cin : 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int unsigned IW = WIDTH - k * S;
        localparam int unsigned LW = (k + 1) * S;

        logic [IW-1:0]            op_a;
        logic [IW-1:0]            op_b;
        logic                     op_v;
        logic                     op_c;
        logic [S-1:0]             slice_s;
        logic [LW-1:0]            low_nx;
        logic [BLK_PER_STAGE-1:0] blk_p;
        logic [BLK_PER_STAGE-1:0] blk_g;
        logic [BLK_PER_STAGE-1:0] blk_co;
        logic [BLK_PER_STAGE:0]   blk_c;
        logic                     unused_co;
        logic                     v_q;
        logic                     c_q;
        logic [LW-1:0]            s_q;

        if (k == 0) begin : g_src
            assign op_a   = in_a_q;
            assign op_b   = in_b_q;
            assign op_v   = in_v_q;
            assign op_c   = in_c_q;
            assign low_nx = slice_s;
        end else begin : g_src
            assign op_a   = g_stage[k-1].g_fwd.a_q;
            assign op_b   = g_stage[k-1].g_fwd.b_q;
            assign op_v   = g_stage[k-1].v_q;
            assign op_c   = g_stage[k-1].c_q;
            assign low_nx = {slice_s, g_stage[k-1].s_q};
        end

        for (genvar j = 0; j < BLK_PER_STAGE; j++) begin : g_blk
            cla_block #(
                .BLK(BLK)
            ) u_cla (
                .a   (op_a[j*BLK +: BLK]),
                .b   (op_b[j*BLK +: BLK]),
                .cin (blk_c[j]),
                .s   (slice_s[j*BLK +: BLK]),
                .cout(blk_co[j]),
                .p   (blk_p[j]),
                .g   (blk_g[j])
            );
        end

        // Block-to-block carries come from group G/P only.
        always_comb begin
            blk_c[0] = op_c;
            for (int j = 0; j < BLK_PER_STAGE; j++) begin
                blk_c[j+1] = blk_g[j] | (blk_p[j] & blk_c[j]);
            end
        end

        assign unused_co = ^blk_co;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (!stall) begin
                v_q <= op_v;
                if (op_v) begin
                    c_q <= blk_c[BLK_PER_STAGE];
                    s_q <= low_nx;
                end
            end
        end

        if (k < NSTAGE - 1) begin : g_fwd
            logic [IW-S-1:0] a_q;
            logic [IW-S-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall && op_v) begin
                    a_q <= op_a[IW-1:S];
                    b_q <= op_b[IW-1:S];
                end
            end
        end else begin : g_last
            logic c_msb;
            logic o_q;

            // Carry into the MSB recovered from its sum bit.
            assign c_msb = op_a[S-1] ^ op_b[S-1] ^ slice_s[S-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    o_q <= 1'b0;
                end else if (!stall && op_v) begin
                    o_q <= c_msb ^ blk_c[BLK_PER_STAGE];
                end
            end
        end
    end

    assign out_valid = g_stage[NSTAGE-1].v_q;
    assign sum       = g_stage[NSTAGE-1].s_q;
    assign cout      = g_stage[NSTAGE-1].c_q;
    assign ovf       = g_stage[NSTAGE-1].g_last.o_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed add/sub cases, backpressure streaming, reset in flight and
// a randomized 32-bit regression, all against an arithmetic reference model.
module tb_pipelined_cla_adder;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 16/4/1 instance
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;
    // 32/4/2 instance
    logic        in_valid_w, in_ready_w, cin_w, sub_w, out_valid_w, out_ready_w, cout_w, ovf_w;
    logic [31:0] a_w, b_w, sum_w;

    int n_checks = 0;
    int n_fail   = 0;

    // Ops in flight, indexed by non-stalled edges since acceptance; slot LAT is the output.
    logic        mv   [0:LAT];
    logic [65:0] mres [0:LAT];
    int          consumed;

    pipelined_cla_adder #(.WIDTH(16), .BLK(4), .BLK_PER_STAGE(1)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf)
    );

    pipelined_cla_adder #(.WIDTH(32), .BLK(4), .BLK_PER_STAGE(2)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .a(a_w), .b(b_w),
        .cin(cin_w), .sub(sub_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .sum(sum_w), .cout(cout_w), .ovf(ovf_w)
    );

    // {ovf, cout, sum}: {cout,sum} = a + (sub ? ~b+1 : b+cin); ovf from true signed result.
    function automatic logic [65:0] ref_model(input int w, input logic [63:0] x,
                                              input logic [63:0] y, input logic ci,
                                              input logic sb);
        logic [63:0] mask, addend, tot, lim, s;
        longint      sx, sy, sres;
        logic        c, o;
        mask   = (64'd1 << w) - 64'd1;
        lim    = 64'd1 << (w - 1);
        addend = sb ? (((~y) & mask) + 64'd1) : (y + {63'b0, ci});
        tot    = x + addend;
        s      = tot & mask;
        c      = tot[w];
        sx     = (x >= lim) ? $signed(x) - $signed(mask) - 64'sd1 : $signed(x);
        sy     = (y >= lim) ? $signed(y) - $signed(mask) - 64'sd1 : $signed(y);
        sres   = sb ? (sx - sy) : (sx + sy + longint'(ci));
        o      = (sres >= $signed(lim)) || (sres < -$signed(lim));
        return {o, c, s};
    endfunction

    task automatic clear_model();
        for (int i = 0; i <= LAT; i++) begin
            mv[i]   = 1'b0;
            mres[i] = '0;
        end
        consumed = 0;
    endtask

    // Called with inputs settled before an edge: checks DUT outputs, then advances the model.
    task automatic model_cycle(input string tag, input logic dv, input logic dr,
                               input logic [63:0] ds, input logic dc, input logic dov,
                               input logic iv, input logic ordy, input logic [65:0] nres,
                               output logic acc);
        logic stall_m;
        stall_m = mv[LAT] && !ordy;
        acc     = iv && !stall_m;
        n_checks++;
        if (dv !== mv[LAT]) begin
            n_fail++;
            $display("FAIL %s out_valid: got %b expected %b", tag, dv, mv[LAT]);
        end
        n_checks++;
        if (dr !== !stall_m) begin
            n_fail++;
            $display("FAIL %s in_ready: got %b expected %b", tag, dr, !stall_m);
        end
        if (mv[LAT]) begin
            n_checks++;
            if ({dov, dc, ds} !== mres[LAT]) begin
                n_fail++;
                $display("FAIL %s result: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                         tag, dov, dc, ds, mres[LAT][65], mres[LAT][64], mres[LAT][63:0]);
            end
            if (ordy) consumed++;
        end
        if (!stall_m) begin
            for (int i = LAT; i > 0; i--) begin
                mv[i]   = mv[i-1];
                mres[i] = mres[i-1];
            end
            mv[0]   = iv;
            mres[0] = nres;
        end
    endtask

    task automatic do_op(input string name, input logic [15:0] xa, input logic [15:0] xb,
                         input logic xc, input logic xs, input logic [15:0] es,
                         input logic ec, input logic eo);
        int lat;
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: in_ready got %b expected 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~xa; b = ~xb;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
        end
        n_checks++;
        if ({ovf, cout, sum} !== {eo, ec, es}) begin
            n_fail++;
            $display("FAIL %s result: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                     name, ovf, cout, sum, eo, ec, es);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, in_ready, cout, ovf} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid=%b ready=%b cout=%b ovf=%b expected 0 1 0 0",
                     out_valid, in_ready, cout, ovf);
        end
        n_checks++;
        if (sum !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_sum: got %h expected 0000", sum);
        end
        n_checks++;
        if ({out_valid_w, in_ready_w, sum_w} !== {2'b01, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_wide: got valid=%b ready=%b sum=%h expected 0 1 0",
                     out_valid_w, in_ready_w, sum_w);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        do_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("add_cin",    16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        int          pat [6] = '{1, 0, 0, 1, 0, 1};
        logic [15:0] oa [8];
        logic [15:0] ob [8];
        logic        oc [8];
        logic        os [8];
        int          k;
        int          cyc;
        logic        acc;
        for (int i = 0; i < 8; i++) begin
            oa[i] = 16'($urandom);
            ob[i] = 16'($urandom);
            oc[i] = 1'($urandom);
            os[i] = 1'($urandom);
        end
        clear_model();
        k   = 0;
        cyc = 0;
        while ((k < 8 || consumed < 8) && cyc < 80) begin
            in_valid = (k < 8);
            if (k < 8) begin
                a = oa[k]; b = ob[k]; cin = oc[k]; sub = os[k];
            end
            out_ready = (pat[cyc % 6] != 0);
            #1;
            model_cycle("b2b", out_valid, in_ready, {48'b0, sum}, cout, ovf, in_valid, out_ready,
                        ref_model(16, {48'b0, a}, {48'b0, b}, cin, sub), acc);
            if (acc) k++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (cyc >= 80) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d results after %0d cycles expected 8", consumed, cyc);
        end
    endtask

    task automatic test_reset_inflight();
        logic acc;
        clear_model();
        for (int c = 0; c < 5; c++) begin
            in_valid  = (c < 3);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = (c < 4);
            #1;
            model_cycle("pre_reset", out_valid, in_ready, {48'b0, sum}, cout, ovf, in_valid,
                        out_ready, ref_model(16, {48'b0, a}, {48'b0, b}, cin, sub), acc);
            @(posedge clk); #1;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_setup: out_valid got %b expected 1", out_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_async: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        clear_model();
        for (int c = 0; c < 8; c++) begin
            #1;
            model_cycle("post_reset", out_valid, in_ready, {48'b0, sum}, cout, ovf, 1'b0,
                        out_ready, '0, acc);
            @(posedge clk); #1;
        end
        do_op("post_reset_op", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic acc;
        clear_model();
        for (int cyc = 0; cyc < 310; cyc++) begin
            in_valid_w  = (cyc < 300) && ($urandom_range(0, 3) != 0);
            out_ready_w = (cyc >= 300) || ($urandom_range(0, 1) != 0);
            a_w   = $urandom;
            b_w   = $urandom;
            cin_w = 1'($urandom);
            sub_w = 1'($urandom);
            if ($urandom_range(0, 7) == 0) a_w = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) b_w = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) b_w = 32'h0000_0000;
            #1;
            model_cycle("random", out_valid_w, in_ready_w, {32'b0, sum_w}, cout_w, ovf_w,
                        in_valid_w, out_ready_w,
                        ref_model(32, {32'b0, a_w}, {32'b0, b_w}, cin_w, sub_w), acc);
            @(posedge clk); #1;
        end
        in_valid_w = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid_w = 1'b0; a_w = '0; b_w = '0; cin_w = 1'b0; sub_w = 1'b0; out_ready_w = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
